pixel_line_fetch: RTL and testbench

PIXEL_LINE_FETCH -- requirements
Module: pixel_line_fetch

---
 rtl/pixel_line_fetch_pkg.sv | 25 ++
 rtl/line_ram.sv | 24 ++
 rtl/pixel_line_fetch.sv | 186 ++++++++++++++++++
 tb/tb_pixel_line_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_line_fetch_pkg.sv
// Shared video definitions: fetch FSM encoding, RGB565 layout and default geometry.
package pixel_line_fetch_pkg;

  localparam int unsigned RdHDefault = 480;
  localparam int unsigned RdVDefault = 272;

  localparam int unsigned RWidth   = 5;
  localparam int unsigned GWidth   = 6;
  localparam int unsigned BWidth   = 5;
  localparam int unsigned PixWidth = RWidth + GWidth + BWidth;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill,
    StDone
  } fetch_state_e;

  typedef struct packed {
    logic [RWidth-1:0] r;
    logic [GWidth-1:0] g;
    logic [BWidth-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port. Contents are not reset.
module line_ram #(
  parameter int unsigned Depth = 480,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_line_fetch.sv
// Ping-pong line buffer between a line-fetch memory port and the pixel timing stage.
module pixel_line_fetch
  import pixel_line_fetch_pkg::*;
#(
  parameter int unsigned RD_H   = RdHDefault,
  parameter int unsigned RD_V   = RdVDefault,
  parameter logic [15:0] BORDER = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                I_hs,
  input  logic                I_vs,
  input  logic                I_de,
  input  logic                I_rd,
  output logic                mem_req,
  output logic [8:0]          mem_line,
  input  logic                mem_ack,
  input  logic                mem_wvalid,
  input  logic [15:0]         mem_wdata,
  output logic                O_hs,
  output logic                O_vs,
  output logic                O_de,
  output logic [RWidth-1:0]   O_r,
  output logic [GWidth-1:0]   O_g,
  output logic [BWidth-1:0]   O_b,
  output logic                O_underrun
);

  localparam int unsigned AddrW = $clog2(RD_H);

  logic             rd_q, vs_q, rd_rise, rd_fall, vs_rise;
  logic [AddrW-1:0] rd_x_q, rd_x;
  logic [8:0]       rd_y_q, next_line;
  logic             disp_bank, line_ok_q, pix_ok;
  logic [AddrW-1:0] addr_q;
  logic             ok_s1_q, bank_s1_q, ok_s2_q, bank_s2_q;
  logic [2:0]       sync_s1_q, sync_s2_q;

  fetch_state_e     state_q, state_d;
  logic [8:0]       line_q, line_d;
  logic [AddrW-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0]       valid_q, valid_d;
  logic             underrun_q, underrun_d;
  logic             line_trig, fill_we;
  logic [1:0]       bank_we;

  logic [PixWidth-1:0] rdata [2];
  rgb565_t             pix;

  assign rd_rise   = I_rd & ~rd_q;
  assign rd_fall   = ~I_rd & rd_q;
  assign vs_rise   = I_vs & ~vs_q;
  assign rd_x      = rd_rise ? '0 : rd_x_q;
  assign disp_bank = rd_y_q[0];
  assign next_line = rd_y_q + 9'd1;
  assign line_trig = rd_rise & (({1'b0, rd_y_q} + 10'd1) < 10'(RD_V));
  // Line validity is sampled at the start of the line so a line never switches mid-way.
  assign pix_ok    = I_rd & (rd_rise ? valid_q[disp_bank] : line_ok_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 1'b0;
      vs_q      <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      line_ok_q <= 1'b0;
      addr_q    <= '0;
      ok_s1_q   <= 1'b0;
      bank_s1_q <= 1'b0;
      sync_s1_q <= '0;
      ok_s2_q   <= 1'b0;
      bank_s2_q <= 1'b0;
      sync_s2_q <= '0;
    end else begin
      rd_q <= I_rd;
      vs_q <= I_vs;
      if (I_rd) rd_x_q <= rd_x + 1'b1;
      if (vs_rise) rd_y_q <= '0;
      else if (rd_fall) rd_y_q <= next_line;
      if (rd_rise) line_ok_q <= valid_q[disp_bank];
      addr_q    <= rd_x;
      ok_s1_q   <= pix_ok;
      bank_s1_q <= disp_bank;
      sync_s1_q <= {I_hs, I_vs, I_de};
      ok_s2_q   <= ok_s1_q;
      bank_s2_q <= bank_s1_q;
      sync_s2_q <= sync_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      line_q     <= '0;
      fill_cnt_q <= '0;
      valid_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    fill_cnt_d = fill_cnt_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;
    if (rd_rise && !valid_q[disp_bank]) underrun_d = 1'b1;
    if (rd_fall) valid_d[disp_bank] = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StReq: begin
        if (mem_ack) begin
          state_d    = StFill;
          fill_cnt_d = '0;
        end
      end
      StFill: begin
        if (mem_wvalid) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == AddrW'(RD_H - 1)) state_d = StDone;
        end
      end
      StDone: begin
        state_d             = StIdle;
        valid_d[line_q[0]]  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // A new frame always wins: any fill in flight is abandoned and line 0 restarts.
    if (vs_rise) begin
      if (state_q != StIdle) valid_d = 2'b00;
      else valid_d[0] = 1'b0;
      state_d = StReq;
      line_d  = '0;
    end else if (line_trig) begin
      if (state_q == StIdle) begin
        state_d                = StReq;
        line_d                 = next_line;
        valid_d[next_line[0]]  = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  assign fill_we = (state_q == StFill) & mem_wvalid;
  assign bank_we = fill_we ? (line_q[0] ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_ram #(
      .Depth(RD_H),
      .Width(PixWidth),
      .AddrW(AddrW)
    ) u_ram (
      .clk  (clk),
      .we   (bank_we[b]),
      .waddr(fill_cnt_q),
      .wdata(mem_wdata),
      .raddr(addr_q),
      .rdata(rdata[b])
    );
  end

  always_comb begin
    pix = '0;
    if (ok_s2_q) pix = rgb565_t'(rdata[bank_s2_q]);
    else if (sync_s2_q[0]) pix = rgb565_t'(BORDER);
  end

  assign {O_hs, O_vs, O_de} = sync_s2_q;
  assign O_r        = pix.r;
  assign O_g        = pix.g;
  assign O_b        = pix.b;
  assign mem_req    = (state_q == StReq);
  assign mem_line   = line_q;
  assign O_underrun = underrun_q;

endmodule

// File: tb/tb_pixel_line_fetch.sv
// Directed bench for pixel_line_fetch: vector table for sync/border paths plus fetch sequences.
module tb_pixel_line_fetch;
  import pixel_line_fetch_pkg::*;

  localparam int unsigned RdH      = 480;
  localparam logic [15:0] BorderPx = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        I_hs = 0, I_vs = 0, I_de = 0, I_rd = 0;
  logic        mem_req, mem_ack, mem_wvalid;
  logic [8:0]  mem_line;
  logic [15:0] mem_wdata;
  logic        O_hs, O_vs, O_de, O_underrun;
  logic [4:0]  O_r, O_b;
  logic [5:0]  O_g;

  logic        resp_en = 0;
  logic        r_ack = 0, r_wvalid = 0, h_ack = 0, h_wvalid = 0;
  logic [15:0] r_wdata = 0, h_wdata = 0;
  logic        nx_ack = 0, nx_wvalid = 0;
  logic [15:0] nx_wdata = 0;
  int          r_line;

  assign mem_ack    = resp_en ? r_ack : h_ack;
  assign mem_wvalid = resp_en ? r_wvalid : h_wvalid;
  assign mem_wdata  = resp_en ? r_wdata : h_wdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        chk;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] px;
  } exp_t;
  exp_t exp0 = '0, exp1 = '0;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] px;
  } vec_t;
  vec_t vecs[10];

  pixel_line_fetch #(
    .RD_H  (RdH),
    .RD_V  (272),
    .BORDER(BorderPx)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .I_hs      (I_hs),
    .I_vs      (I_vs),
    .I_de      (I_de),
    .I_rd      (I_rd),
    .mem_req   (mem_req),
    .mem_line  (mem_line),
    .mem_ack   (mem_ack),
    .mem_wvalid(mem_wvalid),
    .mem_wdata (mem_wdata),
    .O_hs      (O_hs),
    .O_vs      (O_vs),
    .O_de      (O_de),
    .O_r       (O_r),
    .O_g       (O_g),
    .O_b       (O_b),
    .O_underrun(O_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input int line, input int i);
    return 16'((line << 9) | i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Outputs seen at a falling edge belong to the inputs applied two falling edges earlier.
  task automatic cyc(input logic hs, input logic vs, input logic de, input logic rd,
                     input logic [15:0] px, input logic c);
    @(negedge clk);
    if (exp1.chk)
      check("video", {13'd0, O_hs, O_vs, O_de, O_r, O_g, O_b},
            {13'd0, exp1.hs, exp1.vs, exp1.de, exp1.px});
    exp1     = exp0;
    exp0.chk = c;
    exp0.hs  = hs;
    exp0.vs  = vs;
    exp0.de  = de;
    exp0.px  = px;
    I_hs = hs; I_vs = vs; I_de = de; I_rd = rd;
    h_ack = nx_ack; h_wvalid = nx_wvalid; h_wdata = nx_wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    I_hs = 0; I_vs = 0; I_de = 0; I_rd = 0;
    h_ack = 0; h_wvalid = 0; h_wdata = 0;
    nx_ack = 0; nx_wvalid = 0; nx_wdata = 0;
    exp0 = '0;
    exp1 = '0;
    #1;
    check("reset_outs", {2'd0, O_hs, O_vs, O_de, O_r, O_g, O_b, mem_req, mem_line, O_underrun},
          32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic frame_start();
    cyc(0, 1, 0, 0, 16'h0, 1);
    cyc(0, 1, 0, 0, 16'h0, 1);
    check("frame_req", {22'd0, mem_req, mem_line}, {22'd0, 1'b1, 9'd0});
    cyc(0, 1, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 0, 16'h0, 1);
  endtask

  task automatic show_line(input int line, input bit ok, input int req_line);
    cyc(0, 0, 1, 0, BorderPx, 1);
    cyc(0, 0, 1, 0, BorderPx, 1);
    for (int n = 0; n < RdH; n++) begin
      cyc(0, 0, 1, 1, ok ? word_of(line, n) : BorderPx, 1);
      if (n == 1 && req_line >= 0)
        check("line_req", {22'd0, mem_req, mem_line}, {22'd0, 1'b1, 9'(req_line)});
    end
    cyc(0, 0, 1, 0, BorderPx, 1);
    cyc(0, 0, 1, 0, BorderPx, 1);
    idle(30);
  endtask

  // Memory responder: one-cycle ack, then a full line of back-to-back words.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && mem_req && !rst) begin
        r_line = int'(mem_line);
        r_ack  = 1;
        @(negedge clk);
        r_ack = 0;
        for (int i = 0; i < RdH; i++) begin
          r_wvalid = 1;
          r_wdata  = word_of(r_line, i);
          @(negedge clk);
        end
        r_wvalid = 0;
      end
    end
  end

  initial begin
    vecs[0] = '{hs: 0, vs: 0, de: 0, px: 16'h0000};
    vecs[1] = '{hs: 1, vs: 0, de: 0, px: 16'h0000};
    vecs[2] = '{hs: 0, vs: 0, de: 1, px: BorderPx};
    vecs[3] = '{hs: 1, vs: 0, de: 1, px: BorderPx};
    vecs[4] = '{hs: 0, vs: 1, de: 0, px: 16'h0000};
    vecs[5] = '{hs: 0, vs: 1, de: 1, px: BorderPx};
    vecs[6] = '{hs: 1, vs: 1, de: 1, px: BorderPx};
    vecs[7] = '{hs: 0, vs: 0, de: 1, px: BorderPx};
    vecs[8] = '{hs: 1, vs: 0, de: 0, px: 16'h0000};
    vecs[9] = '{hs: 0, vs: 0, de: 0, px: 16'h0000};

    do_reset();
    for (int i = 0; i < 10; i++) cyc(vecs[i].hs, vecs[i].vs, vecs[i].de, 0, vecs[i].px, 1);
    idle(2);

    // First frame: line 0 fetch, then line 1 fetched during line 0 display.
    do_reset();
    resp_en = 1;
    frame_start();
    idle(490);
    check("valid_line0", {30'd0, dut.valid_q}, 32'd1);
    show_line(0, 1, 1);
    show_line(1, 1, 2);
    check("no_underrun", {31'd0, O_underrun}, 32'd0);

    // Withheld ack: line 1 underruns and shows border; flag is sticky.
    idle(20);
    frame_start();
    idle(490);
    resp_en = 0;
    show_line(0, 1, 1);
    check("underrun_before", {31'd0, O_underrun}, 32'd0);
    show_line(1, 0, 1);
    check("underrun_set", {31'd0, O_underrun}, 32'd1);
    frame_start();
    check("underrun_sticky", {31'd0, O_underrun}, 32'd1);

    // Frame restart during the fill of line 1, after 200 words.
    do_reset();
    resp_en = 1;
    frame_start();
    idle(490);
    check("valid_line0_b", {30'd0, dut.valid_q}, 32'd1);
    resp_en = 0;
    cyc(0, 0, 1, 0, BorderPx, 1);
    cyc(0, 0, 1, 0, BorderPx, 1);
    for (int n = 0; n < 202; n++) begin
      nx_ack    = (n == 1);
      nx_wvalid = (n >= 2);
      nx_wdata  = 16'(16'hD000 + n);
      cyc(0, 0, 1, 1, word_of(0, n), 1);
    end
    check("pre_abort_valid", {30'd0, dut.valid_q}, 32'd1);
    nx_ack    = 0;
    nx_wvalid = 0;
    cyc(0, 1, 1, 1, word_of(0, 202), 1);
    cyc(0, 1, 1, 0, BorderPx, 1);
    check("abort_req", {20'd0, mem_req, mem_line, dut.valid_q}, {20'd0, 1'b1, 9'd0, 2'b00});
    cyc(0, 0, 0, 0, 16'h0, 1);
    idle(5);

    // Reset at word 100 of a fill; trailing words must be ignored.
    nx_ack = 1;
    cyc(0, 0, 0, 0, 16'h0, 1);
    nx_ack = 0;
    for (int n = 0; n < 100; n++) begin
      nx_wvalid = 1;
      nx_wdata  = 16'hBEEF;
      cyc(0, 0, 0, 0, 16'h0, 1);
    end
    do_reset();
    for (int n = 0; n < 50; n++) begin
      nx_wvalid = 1;
      nx_wdata  = 16'hBEEF;
      cyc(0, 0, 0, 0, 16'h0, 1);
    end
    nx_wvalid = 0;
    check("post_reset", {28'd0, mem_req, dut.valid_q, O_underrun}, 32'd0);
    resp_en = 1;
    idle(2);
    frame_start();
    idle(490);
    check("valid_after_rst", {30'd0, dut.valid_q}, 32'd1);
    show_line(0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
